// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: memory-mapped 4-digit multiplexed 7-segment scanner.
// Registers (word offsets from BASE_ADDR): 0 DATA[15:0], 1 MASK[3:0],
// 2 STATUS = {29'b0, state, idx} (read-only, SHOW=1). Anything else reads 0.
// Bus handshake: a write is taken on every clk edge with writeEnable=1, a
// read is taken on every clk edge with readEnable=1 and its data appears on
// readData after that edge, holding until the next read. There is no stall.
// Each digit slot lasts REFRESH_DIV cycles; the first BLANK_CYCLES of a slot
// are blanked to hide ghosting while the anode switches.
module seg_scan_ctrl #(
   parameter int          REFRESH_DIV  = 100000,
   parameter int          BLANK_CYCLES = 1000,
   parameter logic [29:0] BASE_ADDR    = 30'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] memAddress,
   input  logic [31:0] writeData,
   input  logic        writeEnable,
   input  logic        readEnable,
   output logic [31:0] readData,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int             CW       = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [31:0]    BLANK_W  = 32'(BLANK_CYCLES);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   // With no blank window the scanner never leaves SHOW, including out of reset.
   localparam state_t RST_STATE = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

   state_t         r_state;
   state_t         w_state_next;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_cnt_next;
   logic [1:0]     r_idx;
   logic [1:0]     w_idx_next;
   logic [15:0]    r_data;
   logic [3:0]     r_mask;
   logic [31:0]    r_read_data;
   logic [3:0]     r_an;
   logic [6:0]     r_seg;
   logic [3:0]     w_an_next;
   logic [6:0]     w_seg_next;
   logic [3:0]     w_nibble;
   logic [29:0]    w_offset;
   logic [31:0]    w_read_val;

   // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign w_offset = memAddress - BASE_ADDR;
   assign w_nibble = r_data[{r_idx, 2'b00} +: 4];

   // Scan sequencing: cnt wraps per slot, idx advances on wrap, state follows cnt.
   always_comb begin
      w_cnt_next   = r_cnt + 1'b1;
      w_idx_next   = r_idx;
      w_state_next = ST_SHOW;
      if (r_cnt == CNT_LAST) begin
         w_cnt_next = '0;
         w_idx_next = r_idx + 2'd1;
      end
      if (32'(w_cnt_next) < BLANK_W) begin
         w_state_next = ST_BLANK;
      end
   end

   // Display pattern computed from registered state only (no bus inputs).
   always_comb begin
      w_an_next  = 4'b1111;
      w_seg_next = 7'b1111111;
      if ((r_state == ST_SHOW) && r_mask[r_idx]) begin
         w_an_next  = ~(4'b0001 << r_idx);
         w_seg_next = hex_to_seg(w_nibble);
      end
   end

   // Read mux over the pre-write register values.
   always_comb begin
      w_read_val = 32'h0;
      case (w_offset)
         30'd0:   w_read_val = {16'h0, r_data};
         30'd1:   w_read_val = {28'h0, r_mask};
         30'd2:   w_read_val = {29'h0, r_state, r_idx};
         default: w_read_val = 32'h0;
      endcase
   end

   // Scan state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_state <= RST_STATE;
      end else begin
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_state <= w_state_next;
      end
   end

   // Bus writes into DATA/MASK; STATUS and unmapped offsets are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= 16'h0000;
         r_mask <= 4'b0001;
      end else if (writeEnable) begin
         if (w_offset == 30'd0) begin
            r_data <= writeData[15:0];
         end else if (w_offset == 30'd1) begin
            r_mask <= writeData[3:0];
         end
      end
   end

   // Registered read data, held between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_read_data <= 32'h0;
      end else if (readEnable) begin
         r_read_data <= w_read_val;
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= 4'b1111;
         r_seg <= 7'b1111111;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
      end
   end

   assign readData = r_read_data;
   assign an       = r_an;
   assign seg      = r_seg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plus random bus traffic against seg_scan_ctrl
// with REFRESH_DIV=8, BLANK_CYCLES=2. A reference model tracks elapsed cycles
// since reset and the DATA/MASK contents; expected display and read values
// go into queues when stimulus is applied and are compared after the edge.
module tb_seg_scan_ctrl;

   localparam int DIV   = 8;
   localparam int BLANK = 2;

   // Clock and DUT signals
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [29:0] memAddress = '0;
   logic [31:0] writeData = '0;
   logic        writeEnable = 1'b0;
   logic        readEnable = 1'b0;
   logic [31:0] readData;
   logic [6:0]  seg;
   logic [3:0]  an;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .REFRESH_DIV (DIV),
      .BLANK_CYCLES(BLANK),
      .BASE_ADDR   (30'h0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .memAddress (memAddress),
      .writeData  (writeData),
      .writeEnable(writeEnable),
      .readEnable (readEnable),
      .readData   (readData),
      .seg        (seg),
      .an         (an)
   );

   // Scoreboard
   int          checks = 0;
   int          errors = 0;
   logic [10:0] disp_q[$];
   logic [31:0] rd_q[$];

   // Reference model
   int          m_t;
   logic [15:0] m_data;
   logic [3:0]  m_mask;
   logic [31:0] m_rd;

   function automatic logic [6:0] ref_hex(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
         4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
         4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
         4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Display after an edge, given the cycle count held before that edge.
   function automatic logic [10:0] exp_disp(input int t, input logic [15:0] d,
                                            input logic [3:0] m);
      int         cnt;
      int         idx;
      logic [3:0] a;
      cnt = t % DIV;
      idx = (t / DIV) % 4;
      if (cnt < BLANK || !m[idx]) return {4'hF, 7'h7F};
      a = 4'b1111;
      a[idx] = 1'b0;
      return {a, ref_hex(d[idx*4 +: 4])};
   endfunction

   function automatic logic [31:0] exp_read(input logic [29:0] off, input int t,
                                            input logic [15:0] d, input logic [3:0] m);
      logic       st;
      logic [1:0] ix;
      st = ((t % DIV) >= BLANK);
      ix = 2'((t / DIV) % 4);
      case (off)
         30'd0:   return {16'h0, d};
         30'd1:   return {28'h0, m};
         30'd2:   return {29'h0, st, ix};
         default: return 32'h0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, expv, m_t);
      end
   endtask

   task automatic model_reset();
      m_t    = 0;
      m_data = 16'h0000;
      m_mask = 4'b0001;
      m_rd   = 32'h0;
      disp_q.delete();
      rd_q.delete();
   endtask

   // Driver: one clock cycle with the given bus access, then score it.
   task automatic cycle(input logic we, input logic re, input logic [29:0] addr,
                        input logic [31:0] wd);
      logic [10:0] d;
      memAddress  = addr;
      writeData   = wd;
      writeEnable = we;
      readEnable  = re;
      disp_q.push_back(exp_disp(m_t, m_data, m_mask));
      if (re) rd_q.push_back(exp_read(addr, m_t, m_data, m_mask));
      @(posedge clk);
      #1;
      if (we) begin
         if (addr == 30'd0) m_data = wd[15:0];
         else if (addr == 30'd1) m_mask = wd[3:0];
      end
      m_t++;
      writeEnable = 1'b0;
      readEnable  = 1'b0;
      d = disp_q.pop_front();
      check("display", {21'h0, an, seg}, {21'h0, d});
      if (re) begin
         m_rd = rd_q.pop_front();
         check("read", readData, m_rd);
      end else begin
         check("read_hold", readData, m_rd);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 30'd0, 32'h0);
   endtask

   initial begin
      logic [29:0] ra;
      logic [31:0] rw;
      logic        rwe;
      logic        rre;

      // Reset: outputs blank and read data cleared while rst is high.
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_an", {28'h0, an}, 32'hF);
      check("rst_seg", {25'h0, seg}, 32'h7F);
      check("rst_read", readData, 32'h0);
      rst = 1'b0;
      model_reset();

      // Reset values via the bus: STATUS=0, MASK=1, DATA=0; digit 0 shows '0'.
      cycle(1'b0, 1'b1, 30'd2, 32'h0);
      cycle(1'b0, 1'b1, 30'd1, 32'h0);
      cycle(1'b0, 1'b1, 30'd0, 32'h0);
      idle(10);

      // Full scan with all digits enabled, over more than one wrap.
      cycle(1'b1, 1'b0, 30'd0, 32'hFFFF_1234);
      cycle(1'b1, 1'b0, 30'd1, 32'h0000_000F);
      idle(40);

      // Masking: only digits 0 and 2 lit.
      cycle(1'b1, 1'b0, 30'd1, 32'h0000_0005);
      idle(36);

      // Same-cycle read and write of DATA returns the old value.
      cycle(1'b1, 1'b0, 30'd0, 32'h0000_AAAA);
      cycle(1'b1, 1'b1, 30'd0, 32'h0000_5555);
      check("rw_old", readData, 32'h0000_AAAA);
      cycle(1'b0, 1'b1, 30'd0, 32'h0);
      check("rw_new", readData, 32'h0000_5555);

      // Unmapped offset: write ignored, read returns 0; STATUS write ignored.
      cycle(1'b1, 1'b0, 30'd7, 32'hFFFF_FFFF);
      cycle(1'b1, 1'b0, 30'd2, 32'hFFFF_FFFF);
      cycle(1'b0, 1'b1, 30'd0, 32'h0);
      cycle(1'b0, 1'b1, 30'd1, 32'h0);
      cycle(1'b0, 1'b1, 30'd7, 32'h0);
      check("unmapped_read", readData, 32'h0);

      // Random mixed traffic mid-scan.
      for (int i = 0; i < 48; i++) begin
         ra  = 30'($urandom_range(0, 7));
         rw  = $urandom;
         rwe = 1'($urandom_range(0, 1));
         rre = 1'($urandom_range(0, 1));
         cycle(rwe, rre, ra, rw);
      end

      // Reset mid-scan at slot 2, cnt 5, with a write in flight.
      cycle(1'b1, 1'b0, 30'd1, 32'h0000_000F);
      cycle(1'b1, 1'b0, 30'd0, 32'h0000_9ABC);
      for (int i = 0; i < 200 && (m_t % (4 * DIV)) != (2 * DIV + 5); i++) idle(1);
      check("reach_slot2_cnt5", m_t % (4 * DIV), 2 * DIV + 5);
      check("pre_rst_lit", {28'h0, an}, 32'hB);
      memAddress  = 30'd0;
      writeData   = 32'h0000_BEEF;
      writeEnable = 1'b1;
      rst         = 1'b1;
      #1;
      check("midrst_an", {28'h0, an}, 32'hF);
      check("midrst_seg", {25'h0, seg}, 32'h7F);
      @(posedge clk);
      #1;
      check("midrst_hold_an", {28'h0, an}, 32'hF);
      writeEnable = 1'b0;
      rst         = 1'b0;
      model_reset();
      check("midrst_read", readData, 32'h0);
      cycle(1'b0, 1'b1, 30'd0, 32'h0);
      cycle(1'b0, 1'b1, 30'd1, 32'h0);
      idle(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot (legal range >=2).
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 1000: blanked cycles at the start of each slot (legal range 0..REFRESH_DIV-1).
REQ-003 The module SHALL have parameter BASE_ADDR, default 30'h0: word address of register 0.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock; all state SHALL be in this domain.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port memAddress, input, 30 bits: word address.
REQ-007 The module SHALL have port writeData, input, 32 bits: write data.
REQ-008 The module SHALL have port writeEnable, input, 1 bit: write strobe, one write per high cycle.
REQ-009 The module SHALL have port readEnable, input, 1 bit: read strobe.
REQ-010 The module SHALL have port readData, output, 32 bits: registered read data.
REQ-011 The module SHALL have port seg, output, 7 bits: active-low segment pattern.
REQ-012 The module SHALL have port an, output, 4 bits: active-low anode enables, one-hot-low or all-high.

Function
REQ-013 Register map: offset 0 is DATA, 16 bits (nibble k = digit k); offset 1 is MASK, 4 bits (bit k enables digit k); offset 2 is STATUS, read-only = {29'b0, state, idx[1:0]} with SHOW=1.
REQ-014 A write SHALL update the register at offset (memAddress-BASE_ADDR) on the clk edge where writeEnable=1; only writeData[15:0] (DATA) or [3:0] (MASK) are used; writes to STATUS or unmapped addresses SHALL be ignored.
REQ-015 A read SHALL have latency 1: readData SHALL be loaded on the edge where readEnable=1 and hold until the next read; unmapped addresses SHALL return 0.
REQ-016 If a read and a write target the same register in the same cycle, readData SHALL return the pre-write value.
REQ-017 Counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, idx (2 bits) SHALL advance 0->1->2->3->0.
REQ-018 FSM state BLANK SHALL hold when cnt<BLANK_CYCLES and SHOW otherwise; with BLANK_CYCLES=0 the FSM SHALL remain in SHOW.
REQ-019 In BLANK, an SHALL be 4'b1111.
REQ-020 In SHOW, an SHALL be ~(4'b0001<<idx) if MASK[idx]=1, else 4'b1111.
REQ-021 seg SHALL be the team hex decoder pattern (0-F, active-low) of DATA nibble idx in SHOW with an active, else 7'b1111111.
REQ-022 an and seg SHALL be registered, reflecting the state, idx, DATA and MASK values held in the previous cycle, with no combinational path from bus inputs.
REQ-023 A DATA/MASK write mid-slot SHALL take effect on display one cycle after the write edge, without restarting cnt or idx.
REQ-024 Bus accesses SHALL never stall or alter the scan sequence.

Reset
REQ-025 While rst=1 (asynchronous): cnt=0, idx=0, state=BLANK (SHOW if BLANK_CYCLES=0), DATA=16'h0000, MASK=4'b0001, readData=0, an=4'b1111, seg=7'b1111111.
REQ-026 Reset asserted mid-slot or mid-access SHALL abort immediately, and any write in that cycle SHALL be discarded.
REQ-027 After rst falls, scanning SHALL restart at slot 0, cnt=0.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2, BASE_ADDR=0)
REQ-028 Reset check: pulse rst -> an=1111, seg=1111111, STATUS read returns 0, MASK read returns 0x1.
REQ-029 Full scan: write DATA=0x1234 and MASK=0xF -> each 8-cycle slot shows 2 cycles an=1111, then 6 cycles an=1110/1101/1011/0111 with seg patterns for 4, 3, 2, 1; sequence wraps after 32 cycles.
REQ-030 Masking: MASK=0x5 -> slots 1 and 3 are an=1111 throughout; slots 0 and 2 are lit.
REQ-031 Same-cycle read/write: DATA=0xAAAA, then write 0x5555 and read offset 0 in the same cycle -> readData=0x0000AAAA; the next read returns 0x00005555.
REQ-032 Unmapped access: write offset 7 -> DATA and MASK unchanged; a read of offset 7 returns 0.
REQ-033 Reset mid-scan: assert rst in slot 2 at cnt=5 -> outputs are blanked immediately; after release, slot 0 restarts with the first 2 cycles blank.
